// File: rtl/dtfm_pkg.sv
// Constants and state encoding shared across the telemetry frame path:
// the group writer, the frame former and the group buffer instantiation.
package dtfm_pkg;
   localparam int WORD_W      = 12;
   localparam int ADDR_W      = 10;
   localparam int GROUP_WORDS = 1024;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} wr_state_t;
endpackage

// File: rtl/grp_writer_if.sv
// Raw serial pins plus the write side of the ping-pong group buffers.
interface grp_writer_if
   import dtfm_pkg::*;
;
   logic              iClk;
   logic              iSync;
   logic              iData;
   logic              iRdBank;
   logic [WORD_W-1:0] oWrData;
   logic [ADDR_W-1:0] oWrAddr;
   logic              oWrEn0;
   logic              oWrEn1;
   logic              oBank;
   logic              oGroupDone;
   logic              oOverrun;
   logic              oResync;

   // master: stream source / buffer observer; slave: grp_writer
   modport master (
      output iClk, iSync, iData, iRdBank,
      input  oWrData, oWrAddr, oWrEn0, oWrEn1, oBank, oGroupDone, oOverrun, oResync
   );
   modport slave (
      input  iClk, iSync, iData, iRdBank,
      output oWrData, oWrAddr, oWrEn0, oWrEn1, oBank, oGroupDone, oOverrun, oResync
   );
endinterface

// File: rtl/grp_writer_edge_sync.sv
// Three-flop synchronizer for an asynchronous pin, with rise/fall pulses
// taken from the two oldest stages.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);
   logic [2:0] s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) s <= '0;
      else      s <= {s[1:0], din};
   end

   assign rise = !s[2] &  s[1];
   assign fall =  s[2] & !s[1];
endmodule

// File: rtl/grp_writer.sv
// Serial-to-word front end: recovers dCLK/dFM/dDAT, packs bits into words and
// writes them into the ping-pong group buffers, swapping banks after each group.
module grp_writer
   import dtfm_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input logic         clk,
   input logic         rst,
   grp_writer_if.slave bus
);
   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GROUP_WORDS - 1);

   wr_state_t         state, state_nx;
   logic              clk_fall, sync_rise, unused_clk_rise, unused_sync_fall;
   logic [2:0]        dat_s;
   logic              dbit, unused_dat_tail;
   logic [WORD_W-1:0] sh_q, sh_nx, wr_data_q, wr_data_nx;
   logic [CNT_W-1:0]  cnt_q, cnt_nx;
   logic [ADDR_W-1:0] addr_q, addr_nx, addr_after, wr_addr_q, wr_addr_nx;
   logic              bank_q, bank_nx, rdy_q, rdy_nx, swap_q, swap_nx;
   logic              en0_q, en0_nx, en1_q, en1_nx;
   logic              done_q, done_nx, ovr_q, ovr_nx, resync_q, resync_nx;

   function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] w, input logic b);
      if (MSB_FIRST) return {w[WORD_W-2:0], b};
      else           return {b, w[WORD_W-1:1]};
   endfunction

   edge_sync u_clk_sync  (.clk(clk), .rst(rst), .din(bus.iClk),
                          .rise(unused_clk_rise), .fall(clk_fall));
   edge_sync u_sync_sync (.clk(clk), .rst(rst), .din(bus.iSync),
                          .rise(sync_rise), .fall(unused_sync_fall));

   // Data tap at stage 1 lines up with the edge pulses above
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dat_s <= '0;
      else      dat_s <= {dat_s[1:0], bus.iData};
   end
   assign dbit            = dat_s[1];
   assign unused_dat_tail = dat_s[2];

   always_comb begin
      state_nx   = state;
      sh_nx      = sh_q;
      cnt_nx     = cnt_q;
      bank_nx    = bank_q;
      rdy_nx     = 1'b0;
      swap_nx    = 1'b0;
      wr_data_nx = wr_data_q;
      wr_addr_nx = wr_addr_q;
      en0_nx     = 1'b0;
      en1_nx     = 1'b0;
      done_nx    = 1'b0;
      ovr_nx     = 1'b0;
      resync_nx  = 1'b0;
      addr_after = addr_q;

      if (swap_q) bank_nx = ~bank_q;

      // A completed word is written even if a sync lands in this cycle
      if (rdy_q) begin
         wr_data_nx = sh_q;
         wr_addr_nx = addr_q;
         en0_nx     = ~bank_q;
         en1_nx     = bank_q;
         if (addr_q == LAST_ADDR) begin
            done_nx    = 1'b1;
            ovr_nx     = (bank_q != bus.iRdBank);  // next bank is the one being read
            swap_nx    = 1'b1;
            addr_after = '0;
         end else begin
            addr_after = addr_q + 1'b1;
         end
      end
      addr_nx = addr_after;

      if (sync_rise) begin
         resync_nx = (state == RUN) && ((cnt_q != '0) || (addr_after != '0));
         state_nx  = RUN;
         addr_nx   = '0;
         cnt_nx    = {{(CNT_W-1){1'b0}}, clk_fall};
         sh_nx     = clk_fall ? shift_in('0, dbit) : '0;
      end else if ((state == RUN) && clk_fall) begin
         sh_nx = shift_in(sh_q, dbit);
         if (cnt_q == LAST_BIT) begin
            cnt_nx = '0;
            rdy_nx = 1'b1;
         end else begin
            cnt_nx = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         sh_q      <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         bank_q    <= 1'b0;
         rdy_q     <= 1'b0;
         swap_q    <= 1'b0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
         en0_q     <= 1'b0;
         en1_q     <= 1'b0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
         resync_q  <= 1'b0;
      end else begin
         state     <= state_nx;
         sh_q      <= sh_nx;
         cnt_q     <= cnt_nx;
         addr_q    <= addr_nx;
         bank_q    <= bank_nx;
         rdy_q     <= rdy_nx;
         swap_q    <= swap_nx;
         wr_data_q <= wr_data_nx;
         wr_addr_q <= wr_addr_nx;
         en0_q     <= en0_nx;
         en1_q     <= en1_nx;
         done_q    <= done_nx;
         ovr_q     <= ovr_nx;
         resync_q  <= resync_nx;
      end
   end

   assign bus.oWrData    = wr_data_q;
   assign bus.oWrAddr    = wr_addr_q;
   assign bus.oWrEn0     = en0_q;
   assign bus.oWrEn1     = en1_q;
   assign bus.oBank      = bank_q;
   assign bus.oGroupDone = done_q;
   assign bus.oOverrun   = ovr_q;
   assign bus.oResync    = resync_q;
endmodule

// File: tb/tb_grp_writer.sv
// Bench for grp_writer: drives the raw serial pins and checks buffer writes
// and status pulses against a word-level model of the stream.
module tb_grp_writer;
   import dtfm_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   grp_writer_if bus ();
   grp_writer #(.MSB_FIRST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef logic [ADDR_W+WORD_W:0] wr_t;  // {bank, addr, data}

   int  total = 0, bad = 0;
   wr_t obs_q[$];
   wr_t exp_q[$];
   int  rd_idx = 0;
   int  n_done = 0, n_ovr = 0, n_resync = 0, n_both = 0, n_ovr_alone = 0;
   int  e_done = 0, e_ovr = 0, e_resync = 0;

   bit  m_active = 1'b0;
   int  m_bits = 0, m_word = 0, m_addr = 0;
   bit  m_bank = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         if (bus.oWrEn0 || bus.oWrEn1) obs_q.push_back({bus.oWrEn1, bus.oWrAddr, bus.oWrData});
         if (bus.oWrEn0 && bus.oWrEn1) n_both <= n_both + 1;
         if (bus.oGroupDone) n_done <= n_done + 1;
         if (bus.oOverrun) n_ovr <= n_ovr + 1;
         if (bus.oOverrun && !bus.oGroupDone) n_ovr_alone <= n_ovr_alone + 1;
         if (bus.oResync) n_resync <= n_resync + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: a group is a sequence of 12-bit words, each bit arriving MSB first
   task automatic m_sync();
      if (m_active && (m_bits != 0 || m_addr != 0)) e_resync++;
      m_active = 1'b1;
      m_bits = 0;
      m_word = 0;
      m_addr = 0;
   endtask

   task automatic m_bit(input bit b);
      if (!m_active) return;
      m_word = (m_word * 2 + int'(b)) % (1 << WORD_W);
      m_bits++;
      if (m_bits == WORD_W) begin
         exp_q.push_back({m_bank, ADDR_W'(m_addr), WORD_W'(m_word)});
         if (m_addr == GROUP_WORDS - 1) begin
            e_done++;
            if ((!m_bank) == bus.iRdBank) e_ovr++;
            m_bank = !m_bank;
            m_addr = 0;
         end else begin
            m_addr++;
         end
         m_bits = 0;
         m_word = 0;
      end
   endtask

   task automatic pin_bit(input bit b);
      bus.iData = b;
      bus.iClk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.iClk = 1'b0;
      m_bit(b);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pin_bit_sync(input bit b);
      bus.iData = b;
      bus.iClk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.iClk = 1'b0;
      bus.iSync = 1'b1;
      m_sync();
      m_bit(b);
      repeat (2) @(posedge clk);
      #1;
      bus.iSync = 1'b0;
   endtask

   task automatic send_word(input int w);
      for (int i = WORD_W - 1; i >= 0; i--) pin_bit(w[i]);
   endtask

   task automatic send_sync();
      bus.iSync = 1'b1;
      m_sync();
      repeat (3) @(posedge clk);
      #1;
      bus.iSync = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic rand_bits(input int n);
      for (int i = 0; i < n; i++) pin_bit(bit'($urandom_range(0, 1)));
   endtask

   task automatic do_reset();
      bus.iClk = 1'b0;
      bus.iSync = 1'b0;
      rst = 1'b0;
      m_active = 1'b0;
      m_bank = 1'b0;
      m_addr = 0;
      m_bits = 0;
      m_word = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_writes(input string tag);
      int n_obs;
      repeat (8) @(posedge clk);
      #1;
      n_obs = obs_q.size() - rd_idx;
      check({tag, " count"}, 32'(n_obs), 32'(exp_q.size()));
      while (exp_q.size() != 0 && rd_idx < obs_q.size()) begin
         check({tag, " word"}, 32'(obs_q[rd_idx]), 32'(exp_q.pop_front()));
         rd_idx++;
      end
      exp_q.delete();
      rd_idx = obs_q.size();
      check({tag, " done"}, 32'(n_done), 32'(e_done));
      check({tag, " overrun"}, 32'(n_ovr), 32'(e_ovr));
      check({tag, " resync"}, 32'(n_resync), 32'(e_resync));
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({bus.oWrData, bus.oWrAddr, bus.oWrEn0, bus.oWrEn1, bus.oBank,
                  bus.oGroupDone, bus.oOverrun, bus.oResync});
   endfunction

   initial begin
      int lat;
      bit b;
      bus.iClk = 1'b0;
      bus.iSync = 1'b0;
      bus.iData = 1'b0;
      bus.iRdBank = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", out_vec(), 32'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Bits before any sync are ignored
      rand_bits(15);
      check_writes("nosync");

      // 0xA5C after sync: single strobe on bank 0, addr 0, 4 clk after the last fall
      send_sync();
      for (int i = WORD_W - 1; i >= 1; i--) pin_bit(bit'((12'hA5C >> i) & 1));
      bus.iData = 1'b0;
      bus.iClk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.iClk = 1'b0;
      m_bit(1'b0);
      lat = 0;
      for (int n = 1; n <= 8 && lat == 0; n++) begin
         @(posedge clk);
         #1;
         if (bus.oWrEn0) lat = n;
      end
      check("a5c latency", 32'(lat), 32'd4);
      check("a5c data", 32'(bus.oWrData), 32'hA5C);
      check("a5c addr", 32'(bus.oWrAddr), 32'h0);
      check_writes("a5c");

      // Sync after 5 bits of word 3 discards it and restarts at addr 0
      do_reset();
      send_sync();
      for (int i = 0; i < 3; i++) send_word(int'($urandom_range(0, 4095)));
      rand_bits(5);
      send_sync();
      send_word(int'($urandom_range(0, 4095)));
      check_writes("resync");

      // Sync coincident with a falling iClk: that bit is bit 11 of the first word
      do_reset();
      rand_bits(5);
      b = bit'($urandom_range(0, 1));
      pin_bit_sync(b);
      rand_bits(11);
      repeat (8) @(posedge clk);
      #1;
      check("coincident bit11", 32'(bus.oWrData[WORD_W-1]), 32'(b));
      check_writes("coincident");

      // Full group with the reader on bank 1: done + overrun, then bank 1 addr 0
      do_reset();
      bus.iRdBank = 1'b1;
      send_sync();
      for (int i = 0; i < GROUP_WORDS; i++) send_word(i % (1 << WORD_W));
      check_writes("group");
      check("bank after group", 32'(bus.oBank), 32'(m_bank));
      send_word(int'($urandom_range(0, 4095)));
      check_writes("after swap");
      bus.iRdBank = 1'b0;

      // Reset mid-group after 700 words
      send_sync();
      for (int i = 0; i < 700; i++) send_word(int'($urandom_range(0, 4095)));
      check_writes("pre reset");
      bus.iData = 1'b1;
      bus.iClk = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset mid group", out_vec(), 32'h0);
      bus.iClk = 1'b0;
      m_active = 1'b0;
      m_bank = 1'b0;
      m_addr = 0;
      m_bits = 0;
      m_word = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      rand_bits(24);
      check_writes("post reset nosync");
      send_sync();
      send_word(int'($urandom_range(0, 4095)));
      check_writes("post reset");

      check("both strobes", 32'(n_both), 32'h0);
      check("overrun without done", 32'(n_ovr_alone), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
